cond_branch_unit: RTL and testbench
===================================

Name: cond_branch_unit

Overview:
- Consumer end of the ALU flag interface.
- Captures negative/zero/overflow/carry_out from the 64-bit ALU into an architectural NZCV register on flag-setting instructions (ADDS/SUBS/ANDS).
- Evaluates ARM condition codes for B.cond and CBZ/CBNZ, and decides whether a branch is taken.
- After a taken branch, sequences a fixed-length pipeline flush so the fetch/decode stages discard wrong-path instructions.

Parameters:
- DELAY, 5, gate-level delay in ps units, applied to the combinational condition outputs only; registers use no delay.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch; legal range 1..7.
- BYPASS, 1: 1 = condition evaluation sees this cycle's ALU flags when `set_flags` is high; 0 = always uses the registered NZCV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- alu_negative  input  1  ALU negative flag.
- alu_zero  input  1  ALU zero flag; also the CBZ/CBNZ test (ALU in pass-B mode).
- alu_overflow  input  1  ALU overflow flag.
- alu_carry_out  input  1  ALU carry-out flag.
- set_flags  input  1  current instruction writes NZCV.
- stall  input  1  pipeline hold: freezes the NZCV register and the flush counter; suppresses `take_branch`.
- br_cond  input  1  current instruction is B.cond.
- cond  input  4  ARM condition field for B.cond.
- cbz  input  1  current instruction is CBZ.
- cbnz  input  1  current instruction is CBNZ.
- br_uncond  input  1  current instruction is B/BL.
- take_branch  output  1  combinational: select branch target this cycle.
- flush  output  1  registered: kill wrong-path instructions.
- nzcv  output  4  registered flags, bit order {N,Z,C,V}.

Behaviour:
- Reset (async, reset_n=0):
  - nzcv=4'b0000, flush=0, FSM=IDLE, flush counter=0.
  - take_branch=0 regardless of inputs.
- Flag register:
  - Rising edge with set_flags=1 and stall=0: nzcv <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}.
  - Otherwise nzcv holds.
  - Write latency is one cycle.
- Effective flags `ef`:
  - ef = live ALU flags when BYPASS=1 and set_flags=1.
  - Otherwise ef = nzcv.
- Condition decode of `cond` against ef:
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 HS C
  - 0011 LO !C
  - 0100 MI N
  - 0101 PL !N
  - 0110 VS V
  - 0111 VC !V
  - 1000 HI C&!Z
  - 1001 LS !C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT !Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 NV 1
- take_branch = !stall & FSM==IDLE & (br_uncond | (br_cond & cond_true) | (cbz & alu_zero) | (cbnz & !alu_zero)).
- CBZ/CBNZ always use live alu_zero, never NZCV, and never write NZCV.
- More than one of br_uncond/br_cond/cbz/cbnz high in a cycle is illegal; the bench flags it with an assertion, and RTL ORs the terms.
- FSM states:
  - IDLE: take_branch=1 on an edge -> FLUSH, counter=FLUSH_CYCLES-1, flush=1.
  - FLUSH: flush=1.
    - stall=1: hold state and counter.
    - counter==0: -> IDLE, flush=0.
    - Otherwise: counter decrements.
- Branches presented while in FLUSH are wrong-path: take_branch=0 and nzcv is not written, even if set_flags=1.
- reset_n deasserting mid-FLUSH returns to IDLE immediately (asynchronously); no partial flush resumes.

Decomposition:
- Package `cond_pkg`:
  - typedef enum for the 4-bit condition codes (EQ..NV).
  - typedef packed struct nzcv_t {n,z,c,v}.
  - FSM state enum {IDLE, FLUSH}.
- One natural sub-module: `cond_eval`, purely combinational, taking cond + nzcv_t and producing cond_true.
- The top module holds the flag register, bypass mux and flush FSM.

Test Plan:
- Reset & hold: reset_n=0 with all inputs toggling -> nzcv=0000, flush=0, take_branch=0. Release, set_flags=0 for 5 cycles -> nzcv stays 0000.
- Flag capture + LT:
  - SUBS result flags N=1, Z=0, C=0, V=0 with set_flags=1 -> next cycle nzcv=1000.
  - B.LT (cond=1011) -> take_branch=1, then flush=1 for exactly 2 cycles.
- Bypass:
  - BYPASS=1, nzcv=0100, set_flags=1 with live Z=0 and B.EQ in the same cycle -> take_branch=0.
  - Same stimulus with BYPASS=0 -> take_branch=1.
- Signed/unsigned boundaries:
  - N=0, V=1 -> GE false, LT true.
  - C=1, Z=1 -> HI false, LS true.
  - AL and NV -> always taken.
- CBZ/CBNZ:
  - alu_zero=1 with cbz -> taken, nzcv unchanged.
  - alu_zero=1 with cbnz -> not taken.
- Stall & wrong-path:
  - Taken branch, then stall=1 for 3 cycles during FLUSH -> flush stays 1 and the counter freezes, so total flush-high cycles = 2 + 3.
  - Branch and set_flags applied during FLUSH -> ignored.
  - reset_n pulsed low mid-FLUSH -> flush=0 immediately.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the branch-condition unit: ARM condition codes, the
// architectural flag word and the flush sequencer states.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Bit order on the wire is {N,Z,C,V}, so n is the MSB.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition-code evaluation against a flag word.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  nzcv_t      flags_i,
    output logic       cond_true_o
);

    // Decode the condition field against the selected flags.
    always_comb begin
        cond_true_o = 1'b0;
        unique case (cond_e'(cond_i))
            COND_EQ: cond_true_o = flags_i.z;
            COND_NE: cond_true_o = !flags_i.z;
            COND_HS: cond_true_o = flags_i.c;
            COND_LO: cond_true_o = !flags_i.c;
            COND_MI: cond_true_o = flags_i.n;
            COND_PL: cond_true_o = !flags_i.n;
            COND_VS: cond_true_o = flags_i.v;
            COND_VC: cond_true_o = !flags_i.v;
            COND_HI: cond_true_o = flags_i.c && !flags_i.z;
            COND_LS: cond_true_o = !flags_i.c || flags_i.z;
            COND_GE: cond_true_o = (flags_i.n == flags_i.v);
            COND_LT: cond_true_o = (flags_i.n != flags_i.v);
            COND_GT: cond_true_o = !flags_i.z && (flags_i.n == flags_i.v);
            COND_LE: cond_true_o = flags_i.z || (flags_i.n != flags_i.v);
            COND_AL: cond_true_o = 1'b1;
            COND_NV: cond_true_o = 1'b1;
            default: cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// Flag register, flag bypass, branch decision and post-branch flush sequencer.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | normal issue; branches may be taken, NZCV may be written
//  ST_FLUSH | wrong-path kill in progress; flush=1, branches/flag writes ignored
module cond_branch_unit
    import cond_pkg::*;
#(
    parameter int DELAY        = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter bit BYPASS       = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_carry_out,
    input  logic       set_flags,
    input  logic       stall,
    input  logic       br_cond,
    input  logic [3:0] cond,
    input  logic       cbz,
    input  logic       cbnz,
    input  logic       br_uncond,
    output logic       take_branch,
    output logic       flush,
    output logic [3:0] nzcv
);

    // DELAY only matters for gate-level back-annotation; RTL stays zero-delay.
    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || DELAY < 0) begin : g_bad_param
            $error("cond_branch_unit: FLUSH_CYCLES must be 1..7 and DELAY non-negative");
        end
    endgenerate

    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

    nzcv_t             nzcv_q, nzcv_d;
    nzcv_t             live_flags;
    nzcv_t             eff_flags;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cond_true;
    logic              branch_hit;
    logic              in_idle;

    assign in_idle = (state_q == ST_IDLE);

    // Live ALU flags and the bypass selection feeding condition evaluation.
    always_comb begin
        live_flags = '{n: alu_negative, z: alu_zero, c: alu_carry_out, v: alu_overflow};
        eff_flags  = nzcv_q;
        if (BYPASS && set_flags) begin
            eff_flags = live_flags;
        end
    end

    cond_eval u_cond_eval (
        .cond_i      (cond),
        .flags_i     (eff_flags),
        .cond_true_o (cond_true)
    );

    // Branch decision; CBZ/CBNZ test the live zero flag, never NZCV.
    always_comb begin
        branch_hit  = br_uncond
                    | (br_cond & cond_true)
                    | (cbz & alu_zero)
                    | (cbnz & !alu_zero);
        take_branch = reset_n & !stall & in_idle & branch_hit;
    end

    // Flag write only from right-path, non-stalled flag-setting instructions.
    always_comb begin
        nzcv_d = nzcv_q;
        if (set_flags && !stall && in_idle) begin
            nzcv_d = live_flags;
        end
    end

    // Flush sequencer next state: load on taken branch, count down unless stalled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take_branch) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            nzcv_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nzcv_q  <= nzcv_d;
        end
    end

    assign flush = (state_q == ST_FLUSH);
    assign nzcv  = nzcv_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Scoreboard bench: two DUTs (bypass on / off) share stimulus; a reference
// model pushes expectations, a monitor pops and compares each cycle.
module tb_cond_branch_unit;

    localparam int FC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic       set_flags, stall, br_cond, cbz, cbnz, br_uncond;
    logic [3:0] cond;
    logic       take_b, take_nb, flush_b, flush_nb;
    logic [3:0] nzcv_b, nzcv_nb;

    cond_branch_unit #(.DELAY(5), .FLUSH_CYCLES(FC), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset_n(reset_n), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .set_flags(set_flags),
        .stall(stall), .br_cond(br_cond), .cond(cond), .cbz(cbz), .cbnz(cbnz),
        .br_uncond(br_uncond), .take_branch(take_b), .flush(flush_b), .nzcv(nzcv_b)
    );

    cond_branch_unit #(.DELAY(5), .FLUSH_CYCLES(FC), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset_n(reset_n), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .set_flags(set_flags),
        .stall(stall), .br_cond(br_cond), .cond(cond), .cbz(cbz), .cbnz(cbnz),
        .br_uncond(br_uncond), .take_branch(take_nb), .flush(flush_nb), .nzcv(nzcv_nb)
    );

    // index 1 = bypass instance, index 0 = registered-only instance
    typedef struct packed {
        logic [1:0] take;
        logic [1:0] flush;
        logic [7:0] nzcv;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_nzcv[2];
    int         m_left[2];

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare every cycle the scoreboard holds an expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            assert ($countones({br_uncond, br_cond, cbz, cbnz}) <= 1)
                else $error("illegal: more than one branch type asserted");
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("take_byp",  {3'b0, take_b},   {3'b0, e.take[1]});
                chk("take_nob",  {3'b0, take_nb},  {3'b0, e.take[0]});
                chk("flush_byp", {3'b0, flush_b},  {3'b0, e.flush[1]});
                chk("flush_nob", {3'b0, flush_nb}, {3'b0, e.flush[0]});
                chk("nzcv_byp",  nzcv_b,  e.nzcv[7:4]);
                chk("nzcv_nob",  nzcv_nb, e.nzcv[3:0]);
            end
        end
    end

    // alu is {N,Z,C,V}
    task automatic cycle(input logic rst, input logic [3:0] alu, input logic sf, input logic st,
                         input logic bc, input logic [3:0] cd, input logic cz, input logic cnz,
                         input logic bu);
        exp_t       e;
        bit         tk[2];
        logic [3:0] ef;
        bit         hit;
        reset_n = rst;
        {alu_negative, alu_zero, alu_carry_out, alu_overflow} = alu;
        set_flags = sf; stall = st; br_cond = bc; cond = cd;
        cbz = cz; cbnz = cnz; br_uncond = bu;
        e = '0;
        for (int b = 0; b < 2; b++) begin
            if (!rst) begin
                m_nzcv[b] = 4'h0;
                m_left[b] = 0;
            end
            ef  = (b == 1 && sf) ? alu : m_nzcv[b];
            hit = bu || (bc && cond_holds(cd, ef)) || (cz && alu[2]) || (cnz && !alu[2]);
            tk[b] = rst && !st && (m_left[b] == 0) && hit;
            e.take[b]  = tk[b];
            e.flush[b] = (m_left[b] > 0);
            e.nzcv[b*4 +: 4] = m_nzcv[b];
        end
        sb.push_back(e);
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                if (m_left[b] > 0) begin
                    if (!st) m_left[b]--;
                end else begin
                    if (sf && !st) m_nzcv[b] = alu;
                    if (tk[b]) m_left[b] = FC;
                end
            end
        end
        #1;
    endtask

    task automatic rand_cycle(input logic rst, input int stall_pct);
        int         kind;
        logic [3:0] a, c;
        kind = $urandom_range(0, 4);
        a    = 4'($urandom);
        c    = 4'($urandom);
        cycle(rst, a, ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) < stall_pct),
              kind == 1, c, kind == 2, kind == 3, kind == 4);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_nzcv[0] = 4'h0; m_nzcv[1] = 4'h0; m_left[0] = 0; m_left[1] = 0;
        reset_n = 1'b0; alu_negative = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
        alu_carry_out = 1'b0; set_flags = 1'b0; stall = 1'b0; br_cond = 1'b0;
        cond = 4'h0; cbz = 1'b0; cbnz = 1'b0; br_uncond = 1'b0;
        @(posedge clk); #1;

        // reset held with toggling inputs, then 5 quiet cycles
        for (int i = 0; i < 4; i++) rand_cycle(1'b0, 20);
        idle(5);

        // SUBS -> N=1, then B.LT taken, flush for FC cycles
        cycle(1, 4'b1000, 1, 0, 0, 4'h0, 0, 0, 0);
        cycle(1, 4'b0000, 0, 0, 1, 4'b1011, 0, 0, 0);
        idle(3);

        // bypass: nzcv=0100, then live Z=0 with B.EQ in the same cycle
        cycle(1, 4'b0100, 1, 0, 0, 4'h0, 0, 0, 0);
        cycle(1, 4'b0000, 1, 0, 1, 4'b0000, 0, 0, 0);
        idle(3);

        // N=0,V=1: GE false, LT true
        cycle(1, 4'b0001, 1, 0, 0, 4'h0, 0, 0, 0);
        cycle(1, 4'b0000, 0, 0, 1, 4'b1010, 0, 0, 0);
        cycle(1, 4'b0000, 0, 0, 1, 4'b1011, 0, 0, 0);
        idle(3);

        // C=1,Z=1: HI false, LS true; AL and NV taken
        cycle(1, 4'b0110, 1, 0, 0, 4'h0, 0, 0, 0);
        cycle(1, 4'b0000, 0, 0, 1, 4'b1000, 0, 0, 0);
        cycle(1, 4'b0000, 0, 0, 1, 4'b1001, 0, 0, 0);
        idle(3);
        cycle(1, 4'b0000, 0, 0, 1, 4'b1110, 0, 0, 0);
        idle(3);
        cycle(1, 4'b1011, 0, 0, 1, 4'b1111, 0, 0, 0);
        idle(3);

        // CBZ taken on live zero, CBNZ not taken; nzcv untouched
        cycle(1, 4'b0100, 0, 0, 0, 4'h0, 1, 0, 0);
        idle(3);
        cycle(1, 4'b0100, 0, 0, 0, 4'h0, 0, 1, 0);
        idle(1);

        // stall freezes the flush for 3 cycles
        cycle(1, 4'b0000, 0, 0, 0, 4'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 4'b0000, 0, 1, 0, 4'h0, 0, 0, 0);
        idle(4);

        // wrong-path branch plus flag write during flush are ignored
        cycle(1, 4'b0000, 0, 0, 0, 4'h0, 0, 0, 1);
        cycle(1, 4'b1111, 1, 0, 0, 4'h0, 0, 0, 1);
        cycle(1, 4'b1010, 1, 0, 1, 4'b1110, 0, 0, 0);
        idle(3);

        // reset pulse mid-flush clears flush immediately
        cycle(1, 4'b0000, 0, 0, 0, 4'h0, 0, 0, 1);
        cycle(0, 4'b0000, 0, 0, 0, 4'h0, 0, 0, 0);
        idle(2);

        // random traffic
        for (int i = 0; i < 500; i++) rand_cycle(($urandom_range(0, 63) != 0), 20);

        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
